// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset controller.
// Holds the state encoding, opcode/funct constants, datapath mux codes and
// the instruction class enum produced by instr_class_decode.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_RALU,
        C_JR,
        C_JALR,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_IALU,
        C_JUMP,
        C_JAL,
        C_ILLEGAL
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_LH    = 6'd33;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SH    = 6'd41;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SLL  = 6'd0;
    localparam logic [5:0] FN_SRL  = 6'd2;
    localparam logic [5:0] FN_JR   = 6'd8;
    localparam logic [5:0] FN_JALR = 6'd9;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_XOR  = 6'd38;
    localparam logic [5:0] FN_NOR  = 6'd39;
    localparam logic [5:0] FN_SLT  = 6'd42;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_JUMP   = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_ALUOUT = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle controller and the datapath.
// Inputs to the controller: opcode/funct from the IR and the memory ready
// handshake. Outputs: every datapath strobe, mux select and status pulse,
// plus the debug state.
// master: controller side; slave: datapath side.
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       lh_ctrl;
    logic       sh_ctrl;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       jal_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       branch_eq;
    logic       branch_neq;
    logic       instr_done;
    logic       illegal;
    logic       mem_err;
    logic [2:0] state;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, pc_src, ir_write, i_or_d, mem_read,
               mem_write, lh_ctrl, sh_ctrl, reg_write, reg_dst, mem_to_reg,
               jal_ctrl, alu_src_a, alu_src_b, alu_op, branch_eq, branch_neq,
               instr_done, illegal, mem_err, state
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, pc_src, ir_write, i_or_d, mem_read,
               mem_write, lh_ctrl, sh_ctrl, reg_write, reg_dst, mem_to_reg,
               jal_ctrl, alu_src_a, alu_src_b, alu_op, branch_eq, branch_neq,
               instr_done, illegal, mem_err, state
    );
endinterface

// File: rtl/instr_class_decode.sv
// Combinational opcode/funct classifier.
// Ports: opcode, funct (in, IR fields); cls (out, instruction class);
//        half (out, 1 for LH/SH halfword accesses).
module instr_class_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output logic         half
);
    always_comb begin
        cls  = C_ILLEGAL;
        half = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (funct)
                    FN_JR:   cls = C_JR;
                    FN_JALR: cls = C_JALR;
                    FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND,
                    FN_OR, FN_XOR, FN_NOR, FN_SLT: cls = C_RALU;
                    default: cls = C_ILLEGAL;
                endcase
            end
            OP_J:                       cls = C_JUMP;
            OP_JAL:                     cls = C_JAL;
            OP_BEQ, OP_BNE:             cls = C_BRANCH;
            OP_ADDI, OP_SLTI, OP_ANDI:  cls = C_IALU;
            OP_LW:                      cls = C_LOAD;
            OP_LH: begin
                cls  = C_LOAD;
                half = 1'b1;
            end
            OP_SW:                      cls = C_STORE;
            OP_SH: begin
                cls  = C_STORE;
                half = 1'b1;
            end
            default:                    cls = C_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset datapath.
// Ports: clk, rst (sync, active-high); bus (master modport of
//        multicycle_controller_if) carrying opcode/funct/mem_ready in and all
//        datapath strobes, status pulses and debug state out.
// Parameters: MEM_TIMEOUT consecutive not-ready cycles before mem_err;
//             CNT_W width of the wait counter.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input logic                    clk,
    input logic                    rst,
    multicycle_controller_if.master bus
);
    state_t       state_r, state_next;
    logic [CNT_W-1:0] wait_cnt;
    instr_class_t cls;
    logic         half;
    logic         waiting;
    logic         timeout;

    instr_class_decode u_decode (
        .opcode (bus.opcode),
        .funct  (bus.funct),
        .cls    (cls),
        .half   (half)
    );

    assign waiting = (state_r == S_FETCH || state_r == S_MEM) && !bus.mem_ready;
    assign timeout = waiting && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state_r <= state_next;
            // A FETCH timeout does not change state, so clear explicitly.
            if (state_next != state_r || !waiting || timeout)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next        = state_r;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_src        = PC_ALU;
        bus.ir_write      = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.lh_ctrl       = 1'b0;
        bus.sh_ctrl       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.jal_ctrl      = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_RT;
        bus.alu_op        = ALU_ADD;
        bus.branch_eq     = 1'b0;
        bus.branch_neq    = 1'b0;
        bus.instr_done    = 1'b0;
        bus.illegal       = 1'b0;
        bus.mem_err       = 1'b0;
        bus.state         = rst ? S_FETCH : state_r;

        // Reset forces every output low combinationally, even mid-store.
        if (!rst) begin
            unique case (state_r)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = SRCB_FOUR;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        state_next   = S_DECODE;
                    end else if (timeout) begin
                        bus.mem_err    = 1'b1;
                        bus.instr_done = 1'b1;
                    end
                end
                S_DECODE: begin
                    bus.alu_src_b = SRCB_IMM_SH;
                    state_next    = S_EXEC;
                    unique case (cls)
                        C_JUMP, C_JAL: begin
                            bus.pc_write   = 1'b1;
                            bus.pc_src     = PC_JUMP;
                            bus.instr_done = 1'b1;
                            bus.reg_write  = (cls == C_JAL);
                            bus.jal_ctrl   = (cls == C_JAL);
                            state_next     = S_FETCH;
                        end
                        C_JR, C_JALR: begin
                            bus.pc_write   = 1'b1;
                            bus.pc_src     = PC_RS;
                            bus.instr_done = 1'b1;
                            bus.reg_write  = (cls == C_JALR);
                            bus.jal_ctrl   = (cls == C_JALR);
                            bus.reg_dst    = (cls == C_JALR);
                            state_next     = S_FETCH;
                        end
                        C_ILLEGAL: begin
                            bus.illegal    = 1'b1;
                            bus.instr_done = 1'b1;
                            state_next     = S_FETCH;
                        end
                        default: ;
                    endcase
                end
                S_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    state_next    = S_FETCH;
                    unique case (cls)
                        C_RALU: begin
                            bus.alu_op = ALU_FUNCT;
                            state_next = S_WB;
                        end
                        C_LOAD, C_STORE: begin
                            bus.alu_src_b = SRCB_IMM;
                            state_next    = S_MEM;
                        end
                        C_BRANCH: begin
                            bus.alu_op        = ALU_SUB;
                            bus.pc_write_cond = 1'b1;
                            bus.pc_src        = PC_ALUOUT;
                            bus.branch_eq     = (bus.opcode == OP_BEQ);
                            bus.branch_neq    = (bus.opcode == OP_BNE);
                            bus.instr_done    = 1'b1;
                        end
                        C_IALU: begin
                            bus.alu_src_b = SRCB_IMM;
                            bus.alu_op    = ALU_ITYPE;
                            state_next    = S_WB;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    bus.i_or_d = 1'b1;
                    if (cls == C_LOAD) begin
                        bus.mem_read = 1'b1;
                        bus.lh_ctrl  = half;
                    end else begin
                        bus.mem_write = 1'b1;
                        bus.sh_ctrl   = half;
                    end
                    if (bus.mem_ready) begin
                        if (cls == C_LOAD) begin
                            state_next = S_WB;
                        end else begin
                            bus.instr_done = 1'b1;
                            state_next     = S_FETCH;
                        end
                    end else if (timeout) begin
                        bus.mem_err    = 1'b1;
                        bus.instr_done = 1'b1;
                        state_next     = S_FETCH;
                    end
                end
                S_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                    bus.reg_dst    = (cls == C_RALU);
                    bus.mem_to_reg = (cls == C_LOAD);
                    bus.lh_ctrl    = (cls == C_LOAD) && half;
                    state_next     = S_FETCH;
                end
                default: state_next = S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller (MEM_TIMEOUT=4).
// A per-cycle vector table drives opcode/funct/mem_ready/rst; each vector's
// expected outputs are queued when driven and compared at the falling edge.
// Hand-written latency sequences follow the table.
module tb_multicycle_controller;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       lh_ctrl;
        logic       sh_ctrl;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       jal_ctrl;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       branch_eq;
        logic       branch_neq;
        logic       instr_done;
        logic       illegal;
        logic       mem_err;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    typedef struct {
        int    idx;
        outs_t exp;
    } sb_t;

    localparam outs_t ZERO   = '0;
    localparam outs_t F_WAIT = '{mem_read: 1'b1, alu_src_b: 2'b01, default: '0};
    localparam outs_t F_RDY  = '{mem_read: 1'b1, alu_src_b: 2'b01, ir_write: 1'b1,
                                 pc_write: 1'b1, default: '0};
    localparam outs_t D_GO   = '{state: 3'd1, alu_src_b: 2'b11, default: '0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];
    sb_t  sb[$];

    multicycle_controller_if bus ();

    multicycle_controller #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic outs_t sample();
        outs_t o;
        o.state         = bus.state;
        o.pc_write      = bus.pc_write;
        o.pc_write_cond = bus.pc_write_cond;
        o.pc_src        = bus.pc_src;
        o.ir_write      = bus.ir_write;
        o.i_or_d        = bus.i_or_d;
        o.mem_read      = bus.mem_read;
        o.mem_write     = bus.mem_write;
        o.lh_ctrl       = bus.lh_ctrl;
        o.sh_ctrl       = bus.sh_ctrl;
        o.reg_write     = bus.reg_write;
        o.reg_dst       = bus.reg_dst;
        o.mem_to_reg    = bus.mem_to_reg;
        o.jal_ctrl      = bus.jal_ctrl;
        o.alu_src_a     = bus.alu_src_a;
        o.alu_src_b     = bus.alu_src_b;
        o.alu_op        = bus.alu_op;
        o.branch_eq     = bus.branch_eq;
        o.branch_neq    = bus.branch_neq;
        o.instr_done    = bus.instr_done;
        o.illegal       = bus.illegal;
        o.mem_err       = bus.mem_err;
        return o;
    endfunction

    function automatic void add(input logic r, input logic [5:0] op,
                                input logic [5:0] fn, input logic rdy,
                                input outs_t e);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.rdy = rdy; v.exp = e;
        tbl.push_back(v);
    endfunction

    // Scoreboard: compare the oldest queued expectation at each falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t   e;
            outs_t a;
            e = sb.pop_front();
            a = sample();
            checks++;
            if (a !== e.exp) begin
                failures++;
                $display("FAIL vec%0d outputs actual=%07h required=%07h",
                         e.idx, a, e.exp);
            end
        end
    end

    task automatic measure(input logic [5:0] op, input logic [5:0] fn,
                           input int exp_lat, input string name);
        int   n = 0;
        logic done = 1'b0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            bus.opcode    = op;
            bus.funct     = fn;
            bus.mem_ready = 1'b1;
            @(negedge clk);
            n++;
            done = bus.instr_done;
        end
        checks++;
        if (!done || n != exp_lat) begin
            failures++;
            $display("FAIL latency_%s actual=%0d done=%0b required=%0d",
                     name, n, done, exp_lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.opcode    = 6'd0;
        bus.funct     = 6'd32;
        bus.mem_ready = 1'b1;

        // reset during FETCH with mem_ready high
        add(1, 0, 32, 1, ZERO);
        add(1, 0, 32, 1, ZERO);
        add(0, 0, 32, 0, F_WAIT);
        // ADD
        add(0, 0, 32, 1, F_RDY);
        add(0, 0, 32, 1, D_GO);
        add(0, 0, 32, 1, '{state: 3'd2, alu_src_a: 1'b1, alu_op: 2'b10, default: '0});
        add(0, 0, 32, 1, '{state: 3'd4, reg_write: 1'b1, reg_dst: 1'b1,
                           instr_done: 1'b1, default: '0});
        // LH with three wait cycles in MEM
        add(0, 33, 0, 1, F_RDY);
        add(0, 33, 0, 1, D_GO);
        add(0, 33, 0, 1, '{state: 3'd2, alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0});
        for (int i = 0; i < 4; i++)
            add(0, 33, 0, (i == 3), '{state: 3'd3, i_or_d: 1'b1, mem_read: 1'b1,
                                      lh_ctrl: 1'b1, default: '0});
        add(0, 33, 0, 1, '{state: 3'd4, reg_write: 1'b1, mem_to_reg: 1'b1,
                           lh_ctrl: 1'b1, instr_done: 1'b1, default: '0});
        // BNE
        add(0, 5, 0, 1, F_RDY);
        add(0, 5, 0, 1, D_GO);
        add(0, 5, 0, 1, '{state: 3'd2, alu_src_a: 1'b1, alu_op: 2'b01,
                          pc_write_cond: 1'b1, pc_src: 2'b11, branch_neq: 1'b1,
                          instr_done: 1'b1, default: '0});
        // JAL then JALR
        add(0, 3, 0, 1, F_RDY);
        add(0, 3, 0, 1, '{state: 3'd1, alu_src_b: 2'b11, pc_write: 1'b1,
                          pc_src: 2'b01, reg_write: 1'b1, jal_ctrl: 1'b1,
                          instr_done: 1'b1, default: '0});
        add(0, 0, 9, 1, F_RDY);
        add(0, 0, 9, 1, '{state: 3'd1, alu_src_b: 2'b11, pc_write: 1'b1,
                          pc_src: 2'b10, reg_write: 1'b1, jal_ctrl: 1'b1,
                          reg_dst: 1'b1, instr_done: 1'b1, default: '0});
        // illegal opcode 63
        add(0, 63, 0, 1, F_RDY);
        add(0, 63, 0, 1, '{state: 3'd1, alu_src_b: 2'b11, illegal: 1'b1,
                           instr_done: 1'b1, default: '0});
        // SW timing out in MEM on the 4th wait cycle
        add(0, 43, 0, 1, F_RDY);
        add(0, 43, 0, 1, D_GO);
        add(0, 43, 0, 1, '{state: 3'd2, alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0});
        for (int i = 0; i < 3; i++)
            add(0, 43, 0, 0, '{state: 3'd3, i_or_d: 1'b1, mem_write: 1'b1, default: '0});
        add(0, 43, 0, 0, '{state: 3'd3, i_or_d: 1'b1, mem_write: 1'b1,
                           mem_err: 1'b1, instr_done: 1'b1, default: '0});
        add(0, 43, 0, 0, F_WAIT);
        // SH interrupted by reset while storing
        add(0, 41, 0, 1, F_RDY);
        add(0, 41, 0, 1, D_GO);
        add(0, 41, 0, 1, '{state: 3'd2, alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0});
        add(0, 41, 0, 0, '{state: 3'd3, i_or_d: 1'b1, mem_write: 1'b1,
                           sh_ctrl: 1'b1, default: '0});
        add(1, 41, 0, 0, ZERO);
        add(0, 41, 0, 0, F_WAIT);
        // FETCH timeout, then ready arriving exactly in the timeout cycle
        add(0, 41, 0, 0, F_WAIT);
        add(0, 41, 0, 0, F_WAIT);
        add(0, 41, 0, 0, '{mem_read: 1'b1, alu_src_b: 2'b01, mem_err: 1'b1,
                           instr_done: 1'b1, default: '0});
        add(0, 2, 0, 0, F_WAIT);
        add(0, 2, 0, 0, F_WAIT);
        add(0, 2, 0, 0, F_WAIT);
        add(0, 2, 0, 1, F_RDY);
        add(0, 2, 0, 1, '{state: 3'd1, alu_src_b: 2'b11, pc_write: 1'b1,
                          pc_src: 2'b01, instr_done: 1'b1, default: '0});
        // ANDI
        add(0, 12, 0, 1, F_RDY);
        add(0, 12, 0, 1, D_GO);
        add(0, 12, 0, 1, '{state: 3'd2, alu_src_a: 1'b1, alu_src_b: 2'b10,
                           alu_op: 2'b11, default: '0});
        add(0, 12, 0, 1, '{state: 3'd4, reg_write: 1'b1, instr_done: 1'b1, default: '0});
        // BEQ
        add(0, 4, 0, 1, F_RDY);
        add(0, 4, 0, 1, D_GO);
        add(0, 4, 0, 1, '{state: 3'd2, alu_src_a: 1'b1, alu_op: 2'b01,
                          pc_write_cond: 1'b1, pc_src: 2'b11, branch_eq: 1'b1,
                          instr_done: 1'b1, default: '0});
        // JR
        add(0, 0, 8, 1, F_RDY);
        add(0, 0, 8, 1, '{state: 3'd1, alu_src_b: 2'b11, pc_write: 1'b1,
                          pc_src: 2'b10, instr_done: 1'b1, default: '0});
        // R-type with unsupported funct 1
        add(0, 0, 1, 1, F_RDY);
        add(0, 0, 1, 1, '{state: 3'd1, alu_src_b: 2'b11, illegal: 1'b1,
                          instr_done: 1'b1, default: '0});

        for (int i = 0; i < tbl.size(); i++) begin
            sb_t e;
            @(posedge clk);
            #1;
            rst           = tbl[i].rst;
            bus.opcode    = tbl[i].op;
            bus.funct     = tbl[i].fn;
            bus.mem_ready = tbl[i].rdy;
            e.idx = i;
            e.exp = tbl[i].exp;
            sb.push_back(e);
        end

        // zero-wait latencies, each starting in FETCH
        measure(6'd35, 6'd0, 5, "lw");
        measure(6'd43, 6'd0, 4, "sw");
        measure(6'd2, 6'd0, 2, "j");
        measure(6'd0, 6'd42, 4, "slt");
        measure(6'd10, 6'd0, 4, "slti");

        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
